// File: rtl/disp_score_writer_if.sv
// Request/response and display-buffer write port of disp_score_writer.
// The master side is the game controller; the slave side is the writer itself.
interface disp_score_writer_if #(
    parameter int BIN_W = 16
);
    logic             i_start;
    logic [BIN_W-1:0] i_value;
    logic             o_busy;
    logic             o_done;
    logic             o_disp_wen;
    logic             o_disp_men;
    logic [6:0]       o_disp_adr;
    logic [3:0]       o_disp_d;

    modport master (
        output i_start,
        output i_value,
        input  o_busy,
        input  o_done,
        input  o_disp_wen,
        input  o_disp_men,
        input  o_disp_adr,
        input  o_disp_d
    );

    modport slave (
        input  i_start,
        input  i_value,
        output o_busy,
        output o_done,
        output o_disp_wen,
        output o_disp_men,
        output o_disp_adr,
        output o_disp_d
    );
endinterface

// File: rtl/disp_score_writer.sv
// Converts a binary readout value to BCD with a sequential double-dabble and
// writes the digits, most significant first, into the 7-segment digit buffer.
module disp_score_writer #(
    parameter int         BIN_W      = 16,
    parameter int         NUM_DIG    = 5,
    parameter logic [6:0] BASE_ADR   = 7'd0,
    parameter int         MAX_DISP   = 128,
    parameter bit         LZ_BLANK   = 1'b1,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic               disp_clk,
    input  logic               rst_disp_n,
    disp_score_writer_if.slave bus
);

    localparam int BCD_W = 4 * NUM_DIG;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DIG_W = $clog2(NUM_DIG + 1);

    function automatic logic [31:0] max_value(input int digits);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    localparam logic [31:0] MAX_VAL = max_value(NUM_DIG);

    generate
        if ((BIN_W < 4) || (BIN_W > 24) || (NUM_DIG < 1) || (NUM_DIG > 7) ||
            (int'(BASE_ADR) + NUM_DIG > MAX_DISP)) begin : g_bad_params
            $error("disp_score_writer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] bin_nxt;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_nxt;
    logic [BCD_W-1:0] bcd_adj;
    logic             sat_q;
    logic             sat_nxt;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [DIG_W-1:0] dig_cnt_q;
    logic [DIG_W-1:0] dig_cnt_nxt;
    logic             seen_nz_q;
    logic             seen_nz_nxt;
    logic [3:0]       top_nib;
    logic             last_dig;

    logic             busy_q;
    logic             busy_nxt;
    logic             done_q;
    logic             done_nxt;
    logic             wen_q;
    logic             wen_nxt;
    logic             men_q;
    logic             men_nxt;
    logic [6:0]       adr_q;
    logic [6:0]       adr_nxt;
    logic [3:0]       d_q;
    logic [3:0]       d_nxt;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The BCD register shifts up one nibble per write, so the top nibble is always the current digit.
    assign top_nib  = bcd_q[BCD_W-1 -: 4];
    assign last_dig = (dig_cnt_q == DIG_W'(NUM_DIG - 1));

    always_comb begin
        state_nxt   = state;
        bin_nxt     = bin_q;
        bcd_nxt     = bcd_q;
        sat_nxt     = sat_q;
        bit_cnt_nxt = bit_cnt_q;
        dig_cnt_nxt = dig_cnt_q;
        seen_nz_nxt = seen_nz_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        wen_nxt     = 1'b1;
        men_nxt     = 1'b1;
        adr_nxt     = adr_q;
        d_nxt       = d_q;

        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt   = CONV;
                    busy_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                    bin_nxt     = bus.i_value;
                    if (32'(bus.i_value) > MAX_VAL) begin
                        sat_nxt = 1'b1;
                        bcd_nxt = {NUM_DIG{4'd9}};
                    end else begin
                        sat_nxt = 1'b0;
                        bcd_nxt = '0;
                    end
                end
            end

            // Always BIN_W iterations so the write window does not depend on saturation.
            CONV: begin
                if (!sat_q) begin
                    {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
                end
                bit_cnt_nxt = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_nxt   = WRITE;
                    dig_cnt_nxt = '0;
                    seen_nz_nxt = 1'b0;
                end
            end

            WRITE: begin
                wen_nxt = 1'b0;
                men_nxt = 1'b0;
                adr_nxt = BASE_ADR + 7'(dig_cnt_q);
                if (LZ_BLANK && !seen_nz_q && (top_nib == 4'd0) && !last_dig) begin
                    d_nxt = BLANK_CODE;
                end else begin
                    d_nxt = top_nib;
                end
                if (top_nib != 4'd0) begin
                    seen_nz_nxt = 1'b1;
                end
                bcd_nxt     = bcd_q << 4;
                dig_cnt_nxt = dig_cnt_q + 1'b1;
                if (last_dig) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge disp_clk or negedge rst_disp_n) begin
        if (!rst_disp_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset drops the enables at once, abandoning any partially written field.
    always_ff @(posedge disp_clk or negedge rst_disp_n) begin
        if (!rst_disp_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            sat_q     <= 1'b0;
            bit_cnt_q <= '0;
            dig_cnt_q <= '0;
            seen_nz_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wen_q     <= 1'b1;
            men_q     <= 1'b1;
            adr_q     <= '0;
            d_q       <= '0;
        end else begin
            bin_q     <= bin_nxt;
            bcd_q     <= bcd_nxt;
            sat_q     <= sat_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            dig_cnt_q <= dig_cnt_nxt;
            seen_nz_q <= seen_nz_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            wen_q     <= wen_nxt;
            men_q     <= men_nxt;
            adr_q     <= adr_nxt;
            d_q       <= d_nxt;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_disp_wen = wen_q;
    assign bus.o_disp_men = men_q;
    assign bus.o_disp_adr = adr_q;
    assign bus.o_disp_d   = d_q;

endmodule

// File: tb/tb_disp_score_writer.sv
// Scoreboard bench for disp_score_writer: three instances cover the default,
// 20-bit saturating, and unblanked/offset configurations.
module tb_disp_score_writer;

    localparam int NUM_DIG = 5;
    localparam int MAX_VAL = 99999;

    typedef struct {
        int         sel;
        logic [6:0] adr;
        logic [3:0] d;
        int         cyc;
    } wr_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       wen;
        logic       men;
        logic [6:0] adr;
        logic [3:0] d;
    } obs_t;

    logic disp_clk = 1'b0;
    logic rst_disp_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];

    always #5 disp_clk = ~disp_clk;

    always @(posedge disp_clk) cyc <= cyc + 1;

    disp_score_writer_if #(.BIN_W(16)) bus_a ();
    disp_score_writer_if #(.BIN_W(20)) bus_b ();
    disp_score_writer_if #(.BIN_W(16)) bus_c ();

    disp_score_writer dut_a (
        .disp_clk   (disp_clk),
        .rst_disp_n (rst_disp_n),
        .bus        (bus_a.slave)
    );

    disp_score_writer #(.BIN_W(20)) dut_b (
        .disp_clk   (disp_clk),
        .rst_disp_n (rst_disp_n),
        .bus        (bus_b.slave)
    );

    disp_score_writer #(.BIN_W(16), .BASE_ADR(7'd40), .LZ_BLANK(1'b0)) dut_c (
        .disp_clk   (disp_clk),
        .rst_disp_n (rst_disp_n),
        .bus        (bus_c.slave)
    );

    function automatic obs_t obs(input int sel);
        obs_t o;
        case (sel)
            0:       o = {bus_a.o_busy, bus_a.o_done, bus_a.o_disp_wen, bus_a.o_disp_men, bus_a.o_disp_adr, bus_a.o_disp_d};
            1:       o = {bus_b.o_busy, bus_b.o_done, bus_b.o_disp_wen, bus_b.o_disp_men, bus_b.o_disp_adr, bus_b.o_disp_d};
            default: o = {bus_c.o_busy, bus_c.o_done, bus_c.o_disp_wen, bus_c.o_disp_men, bus_c.o_disp_adr, bus_c.o_disp_d};
        endcase
        return o;
    endfunction

    task automatic set_inputs(input int sel, input logic start, input int val);
        case (sel)
            0: begin bus_a.i_start = start; bus_a.i_value = 16'(val); end
            1: begin bus_b.i_start = start; bus_b.i_value = 20'(val); end
            default: begin bus_c.i_start = start; bus_c.i_value = 16'(val); end
        endcase
    endtask

    // Decimal reference: plain div/mod with saturation and leading-zero blanking.
    task automatic model_push(input int sel, input int val, input int e0, input int bin_w,
                              input bit lz, input int base);
        int  digs[NUM_DIG];
        int  t;
        int  idx;
        bit  seen;
        wr_t e;
        t = val;
        for (int i = 0; i < NUM_DIG; i++) begin
            digs[i] = (val > MAX_VAL) ? 9 : t % 10;
            t = t / 10;
        end
        seen = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            idx = NUM_DIG - 1 - k;
            if (digs[idx] != 0) seen = 1'b1;
            e.sel = sel;
            e.adr = 7'(base + k);
            e.d   = (lz && !seen && idx != 0) ? 4'hF : 4'(digs[idx]);
            e.cyc = e0 + bin_w + 1 + k;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_start(input int sel, input int val, output int e0);
        @(negedge disp_clk);
        set_inputs(sel, 1'b1, val);
        @(posedge disp_clk);
        #1;
        e0 = cyc;
        set_inputs(sel, 1'b0, val);
    endtask

    task automatic watch_op(input int sel, input int e0, input int bin_w,
                            output int done_cyc, output int done_cnt, output int busy_err);
        obs_t o;
        logic exp_busy;
        done_cyc = -1;
        done_cnt = 0;
        busy_err = 0;
        for (int n = 0; n < bin_w + NUM_DIG + 5; n++) begin
            @(negedge disp_clk);
            o = obs(sel);
            if (o.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            exp_busy = (cyc >= e0) && (cyc <= e0 + bin_w + NUM_DIG);
            if (o.busy !== exp_busy) busy_err++;
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest pending entry.
    always @(negedge disp_clk) begin : monitor
        obs_t o;
        wr_t  e;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            if (o.wen === 1'b0 || o.men === 1'b0) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].sel != i) begin
                    failures++;
                    $display("[TB] FAIL unexpected_write dut=%0d cyc=%0d adr=%0d d=%h", i, cyc, o.adr, o.d);
                end else begin
                    e = exp_q.pop_front();
                    if (o.adr !== e.adr || o.d !== e.d || cyc != e.cyc || o.wen !== 1'b0 || o.men !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL write dut=%0d got adr=%0d d=%h cyc=%0d wen=%b men=%b expected adr=%0d d=%h cyc=%0d wen=0 men=0",
                                 i, o.adr, o.d, cyc, o.wen, o.men, e.adr, e.d, e.cyc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        obs_t o;
        rst_disp_n = 1'b0;
        set_inputs(0, 1'b0, 0);
        set_inputs(1, 1'b0, 0);
        set_inputs(2, 1'b0, 0);
        repeat (3) @(negedge disp_clk);
        o = obs(0);
        checks++;
        if (o !== {1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 4'd0}) begin
            failures++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b wen=%b men=%b adr=%0d d=%h expected 0 0 1 1 0 0",
                     o.busy, o.done, o.wen, o.men, o.adr, o.d);
        end
        rst_disp_n = 1'b1;
        repeat (2) @(negedge disp_clk);
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            checks++;
            if (o !== {1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 4'd0}) begin
                failures++;
                $display("[TB] FAIL idle_after_reset dut=%0d got busy=%b done=%b wen=%b men=%b adr=%0d d=%h expected 0 0 1 1 0 0",
                         i, o.busy, o.done, o.wen, o.men, o.adr, o.d);
            end
        end
    endtask

    task automatic run_and_check(input string name, input int sel, input int val, input int bin_w,
                                 input bit lz, input int base);
        int e0;
        int done_cyc;
        int done_cnt;
        int busy_err;
        drive_start(sel, val, e0);
        model_push(sel, val, e0, bin_w, lz, base);
        watch_op(sel, e0, bin_w, done_cyc, done_cnt, busy_err);
        checks++;
        if (done_cnt != 1 || done_cyc != e0 + bin_w + NUM_DIG + 1) begin
            failures++;
            $display("[TB] FAIL %s_done val=%0d got count=%0d at cyc=%0d expected count=1 at cyc=%0d",
                     name, val, done_cnt, done_cyc, e0 + bin_w + NUM_DIG + 1);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("[TB] FAIL %s_busy val=%0d got %0d wrong cycles expected 0", name, val, busy_err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_missing_writes val=%0d got %0d pending expected 0", name, val, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_basic();
        int vals[6] = '{1234, 0, 65535, 10, 9, 100};
        foreach (vals[i]) run_and_check("basic", 0, vals[i], 16, 1'b1, 0);
        for (int i = 0; i < 3; i++) run_and_check("basic_rand", 0, int'($urandom_range(65535, 0)), 16, 1'b1, 0);
    endtask

    task automatic test_saturation();
        int vals[5] = '{123456, 99999, 100000, 1048575, 54321};
        foreach (vals[i]) run_and_check("sat", 1, vals[i], 20, 1'b1, 0);
    endtask

    task automatic test_no_blank();
        int vals[3] = '{7, 0, 60210};
        foreach (vals[i]) run_and_check("noblank", 2, vals[i], 16, 1'b0, 40);
    endtask

    task automatic test_back_to_back();
        int e0;
        int e1;
        int done_cyc;
        int done_cnt;
        int busy_err;
        drive_start(0, 2468, e0);
        model_push(0, 2468, e0, 16, 1'b1, 0);
        done_cnt = 0;
        done_cyc = -1;
        e1 = -1;
        for (int n = 1; n <= 23; n++) begin
            @(negedge disp_clk);
            if (bus_a.o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            bus_a.i_start = (n == 3 || n == 18 || n == 22 || n == 23);
            bus_a.i_value = (n == 23) ? 16'd4321 : 16'($urandom);
            @(posedge disp_clk);
            #1;
            if (n == 23) e1 = cyc;
            bus_a.i_start = 1'b0;
        end
        model_push(0, 4321, e1, 16, 1'b1, 0);
        checks++;
        if (done_cnt != 1 || done_cyc != e0 + 22) begin
            failures++;
            $display("[TB] FAIL b2b_first_done got count=%0d at cyc=%0d expected count=1 at cyc=%0d",
                     done_cnt, done_cyc, e0 + 22);
        end
        watch_op(0, e1, 16, done_cyc, done_cnt, busy_err);
        checks++;
        if (done_cnt != 1 || done_cyc != e1 + 22 || busy_err != 0) begin
            failures++;
            $display("[TB] FAIL b2b_second_op got done_count=%0d at cyc=%0d busy_err=%0d expected 1 at cyc=%0d busy_err=0",
                     done_cnt, done_cyc, busy_err, e1 + 22);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_missing_writes got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_write();
        int   e0;
        obs_t o;
        drive_start(0, 1234, e0);
        model_push(0, 1234, e0, 16, 1'b1, 0);
        repeat (19) @(posedge disp_clk);
        #1;
        o = obs(0);
        checks++;
        if (o.wen !== 1'b0 || o.adr !== 7'd2 || o.d !== 4'd2) begin
            failures++;
            $display("[TB] FAIL rst_mid_write_cycle2 got wen=%b adr=%0d d=%h expected wen=0 adr=2 d=2",
                     o.wen, o.adr, o.d);
        end
        rst_disp_n = 1'b0;
        #1;
        o = obs(0);
        checks++;
        if (o.wen !== 1'b1 || o.men !== 1'b1 || o.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_async got wen=%b men=%b busy=%b expected 1 1 0", o.wen, o.men, o.busy);
        end
        checks++;
        if (exp_q.size() != 3) begin
            failures++;
            $display("[TB] FAIL rst_mid_consumed got %0d pending expected 3", exp_q.size());
        end
        exp_q.delete();
        repeat (2) @(negedge disp_clk);
        rst_disp_n = 1'b1;
        repeat (25) @(negedge disp_clk);
        run_and_check("after_reset", 0, 1234, 16, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_reset_mid_write();
        test_no_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/disp_score_writer.md
Name: disp_score_writer

Overview:
- Upstream feeder of the 7-segment digit display stage.
- Accepts a binary value plus a start pulse and converts it to BCD with a sequential double-dabble.
- Writes the digits, most significant first, into the display stage's digit buffer through its active-low write/memory-enable port.
- Used for score, lines and level readouts; one instance per readout field, or time-multiplexed by the game controller.

Parameters:
BIN_W, 16, width of input binary value (4..24)
NUM_DIG, 5, number of decimal digits written (1..7)
BASE_ADR, 7'd0, buffer address of the most significant digit
MAX_DISP, 128, buffer depth; BASE_ADR+NUM_DIG <= MAX_DISP is required
LZ_BLANK, 1, 1 = leading zeros replaced by BLANK_CODE
BLANK_CODE, 4'hF, digit code the display stage renders as blank

Ports:
disp_clk  in  1  display clock, all logic on rising edge
rst_disp_n  in  1  asynchronous active-low reset
i_start  in  1  request pulse; sampled only in IDLE
i_value  in  BIN_W  binary value, captured on the accepted start edge
o_busy  out  1  high from start acceptance through the last write cycle
o_done  out  1  one-cycle pulse after the last write
o_disp_wen  out  1  active-low write enable to the display buffer
o_disp_men  out  1  active-low memory enable to the display buffer
o_disp_adr  out  7  buffer address
o_disp_d  out  4  digit code (0-9 or BLANK_CODE)

Behaviour:
- Clock/reset: single clock disp_clk; asynchronous active-low reset rst_disp_n.
- Reset values: state=IDLE; o_busy=0; o_done=0; o_disp_wen=1; o_disp_men=1; o_disp_adr=0; o_disp_d=0. All outputs are registered.
- FSM states: IDLE, CONV, WRITE, DONE.
- IDLE:
  - On i_start=1 at edge E0: capture i_value and go to CONV.
  - Saturation: if i_value > 10^NUM_DIG-1, load the BCD register with all 9s and set the sat flag. Otherwise clear the BCD register and load the shift register with i_value.
  - o_busy=1 from the cycle after E0.
- CONV:
  - Exactly BIN_W cycles (bit counter), independent of saturation, so latency is fixed.
  - Each cycle, when not saturated: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - When saturated: hold the BCD register.
  - After the BIN_W-th iteration, go to WRITE.
- WRITE:
  - NUM_DIG consecutive cycles. In cycle k (k=0..NUM_DIG-1): o_disp_wen=0, o_disp_men=0, o_disp_adr=BASE_ADR+k, o_disp_d = nibble NUM_DIG-1-k.
  - Leading-zero blanking (LZ_BLANK=1): nibbles above the most significant nonzero nibble output BLANK_CODE. The least significant digit is never blanked, so value 0 shows a single "0".
  - Both enables deassert (1) the cycle after the last write.
- DONE: one cycle with o_done=1 and o_busy=0, then IDLE. A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- Timing, relative to start edge E0:
  - Write strobes visible in cycles E0+BIN_W+1 .. E0+BIN_W+NUM_DIG.
  - o_done visible in cycle E0+BIN_W+NUM_DIG+1.
  - With defaults: writes in cycles 17-21, done in cycle 22.
- Start outside IDLE: ignored; the captured value is not disturbed.
- i_value changes after capture: no effect on the conversion in progress.
- Reset mid-operation: enables go to 1 immediately (asynchronously), no further writes, state IDLE. A partially written field is left as is in the buffer.
- Outside WRITE: o_disp_adr and o_disp_d hold their last values; enables stay 1.

Test Plan:
1. Defaults, i_value=1234, start -> writes (adr,d) = (0,F),(1,1),(2,2),(3,3),(4,4) in cycles 17-21; o_done=1 in cycle 22 only.
2. i_value=0 -> (0,F),(1,F),(2,F),(3,F),(4,0); i_value=65535 -> 6,5,5,3,5 with no blanking.
3. BIN_W=20, i_value=123456 (>99999) -> all five digits 9; write window still at cycles 21-25.
4. Start pulses in cycles 3, 18 and 22 of an active operation -> ignored; exactly one write burst; the next start accepted in cycle 23.
5. Assert rst_disp_n=0 during write cycle 2 -> o_disp_wen=o_disp_men=1 and o_busy=0 with no clock edge needed; no further strobes; a new start after release behaves as in test 1.
6. LZ_BLANK=0, BASE_ADR=40, i_value=7 -> (40,0),(41,0),(42,0),(43,0),(44,7).
